// File: rtl/chacha_pkg.sv
// chacha_pkg: shared constants, quarter-round index tables, FSM states and helpers for the ChaCha core
package chacha_pkg;
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  localparam logic [7:0][3:0][3:0] QR_TAB = {
    {4'd14, 4'd9,  4'd4, 4'd3},
    {4'd13, 4'd8,  4'd7, 4'd2},
    {4'd12, 4'd11, 4'd6, 4'd1},
    {4'd15, 4'd10, 4'd5, 4'd0},
    {4'd15, 4'd11, 4'd7, 4'd3},
    {4'd14, 4'd10, 4'd6, 4'd2},
    {4'd13, 4'd9,  4'd5, 4'd1},
    {4'd12, 4'd8,  4'd4, 4'd0}};
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_e;
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ROUND = ST_ROUND;
  localparam logic [1:0] FINAL = ST_FINAL;
  function automatic bit rounds_ok(int r);
    return r inside {8, 12, 20};
  endfunction
  function automatic logic [31:0] rotl(logic [31:0] x, int n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/chacha_if.sv
// chacha_if: request/keystream signals between the register file and the ChaCha core
interface chacha_if;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         busy;
  logic         done;
  logic         ks_valid;
  logic [3:0]   ks_addr;
  logic [31:0]  ks_data;
  logic [31:0]  next_counter;
  logic         ctr_wrap;
  modport master (output start, key, nonce, counter, ks_addr,
                  input busy, done, ks_valid, ks_data, next_counter, ctr_wrap);
  modport slave (input start, key, nonce, counter, ks_addr,
                 output busy, done, ks_valid, ks_data, next_counter, ctr_wrap);
endinterface

// File: rtl/chacha_qr.sv
// chacha_qr: one combinational ChaCha quarter-round
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] qc,
  output logic [31:0] qd
);
  logic [31:0] a1, b1, c1, d1;
  assign a1 = a + b;
  assign d1 = rotl(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl(b ^ c1, 12);
  assign qa = a1 + b1;
  assign qd = rotl(d1 ^ qa, 8);
  assign qc = c1 + qd;
  assign qb = rotl(b1 ^ qc, 7);
endmodule

// File: rtl/chacha_core.sv
// chacha_core: iterative ChaCha block function, one quarter-round per clock
module chacha_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input logic clk,
  input logic reset_n,
  chacha_if.slave bus
);
  localparam int NQR = ROUNDS * 4;
  localparam int CW = $clog2(NQR);
  if (!rounds_ok(ROUNDS)) begin : g_bad_rounds
    $error("chacha_core: ROUNDS must be 8, 12 or 20");
  end
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] qr_idx;
  logic [15:0][31:0] w, in_s, ks, init;
  logic [3:0] ia, ib, ic, id;
  logic [31:0] qa, qb, qc, qd;
  assign init = {bus.nonce, bus.counter, bus.key, SIGMA};
  assign qr_idx = cnt[2:0];
  assign ia = QR_TAB[qr_idx][0];
  assign ib = QR_TAB[qr_idx][1];
  assign ic = QR_TAB[qr_idx][2];
  assign id = QR_TAB[qr_idx][3];
  assign bus.busy = state != IDLE;
  assign bus.ks_data = ks[bus.ks_addr];
  chacha_qr u_qr (
    .a(w[ia]), .b(w[ib]), .c(w[ic]), .d(w[id]),
    .qa(qa), .qb(qb), .qc(qc), .qd(qd)
  );
  // accept a request, run the quarter-rounds in place, then fold in the input state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      w <= '0;
      in_s <= '0;
      ks <= '0;
      bus.done <= 1'b0;
      bus.ks_valid <= 1'b0;
      bus.next_counter <= '0;
      bus.ctr_wrap <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        state <= ROUND;
        cnt <= '0;
        w <= init;
        in_s <= init;
        bus.ks_valid <= 1'b0;
        bus.next_counter <= bus.counter + 32'd1;
        bus.ctr_wrap <= &bus.counter;
      end else if (state == ROUND) begin
        w[ia] <= qa;
        w[ib] <= qb;
        w[ic] <= qc;
        w[id] <= qd;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(NQR - 1)) state <= FINAL;
      end else if (state == FINAL) begin
        for (int i = 0; i < 16; i++) ks[i] <= w[i] + in_s[i];
        bus.done <= 1'b1;
        bus.ks_valid <= 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/chacha_core.md
CHACHA_CORE -- requirements
Module: chacha_core

Interface
REQ-001 Parameter ROUNDS, default 20, number of ChaCha rounds; SHALL be even, legal values 8, 12, 20.
REQ-002 clk  input  1  single clock.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request one keystream block; sampled on the rising edge of clk.
REQ-005 key  input  256  key; key[32i+31:32i] is state word 4+i.
REQ-006 nonce  input  96  nonce; nonce[32i+31:32i] is state word 13+i.
REQ-007 counter  input  32  block counter, state word 12.
REQ-008 busy  output  1  high from the edge that accepts start until done asserts.
REQ-009 done  output  1  one-cycle pulse when the keystream block is written.
REQ-010 ks_valid  output  1  keystream register holds a completed block.
REQ-011 ks_addr  input  4  keystream word select.
REQ-012 ks_data  output  32  keystream word ks_addr; combinational read of the keystream register.
REQ-013 next_counter  output  32  counter+1 mod 2^32, latched when start is accepted.
REQ-014 ctr_wrap  output  1  latched counter was 0xFFFFFFFF.

Function
REQ-015 State words 0..3 SHALL be the constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574.
REQ-016 FSM states SHALL be IDLE, ROUND and FINAL.
- IDLE + start -> ROUND: load the working state and a copy of the input state; set qr_idx=0; clear ks_valid.
REQ-017 ROUND SHALL apply exactly one quarter-round per cycle.
- qr_idx 0..3: columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- qr_idx 4..7: diagonals (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
- qr_idx wraps 7->0; the FSM leaves for FINAL after ROUNDS*4 quarter-rounds.
REQ-018 Quarter-round arithmetic SHALL be 32-bit modulo add, XOR and left-rotates by 16, 12, 8, 7 (RFC 8439).
REQ-019 FINAL SHALL write keystream word i = working word i + input word i (mod 2^32), assert done and ks_valid, and return to IDLE.
REQ-020 Latency SHALL be: done high in the cycle following the edge ROUNDS*4+1 edges after the accepting edge (81 edges for ROUNDS=20).
REQ-021 start while busy SHALL be ignored without side effects.
REQ-022 start in the same cycle done is high SHALL be accepted (FSM is already IDLE).
REQ-023 key, nonce and counter changes while busy SHALL NOT affect the block in progress.
REQ-024 Counter wrap: counter=0xFFFFFFFF SHALL give next_counter=0 and ctr_wrap=1; otherwise ctr_wrap=0.
REQ-025 ks_data SHALL remain stable between done pulses, except that it is undefined-content-preserving while ks_valid=0 (the old block is kept, not cleared, on start).

Reset
REQ-026 reset_n low SHALL asynchronously force the following to 0: FSM=IDLE, busy, done, ks_valid, qr_idx, working state, keystream register, next_counter, ctr_wrap.
REQ-027 reset mid-operation SHALL abort the block; no done pulse SHALL follow the release of reset.
REQ-028 The first start after reset release SHALL behave as from IDLE.

Structure
REQ-029 A shared package chacha_pkg SHALL hold:
- the four sigma constants;
- the quarter-round index tables;
- the FSM state enum;
- the ROUNDS legality check.
REQ-030 Combinational sub-module chacha_qr SHALL be used: four 32-bit in, four 32-bit out, one instance.
REQ-031 The chacha_wb_accel register file drives key/nonce/counter/start and reads ks_data/ks_valid; chacha_core SHALL contain no bus logic.

Verification
REQ-032 RFC 8439 §2.3.2 vector (key bytes 00..1f, nonce words 0x09000000/0x4a000000/0x00000000, counter=1) -> word0=0xe4e7f110, word15=0x4e3c50a2, done exactly 81 edges after start.
REQ-033 All-zero key, nonce and counter -> word0=0xade0b876; ctr_wrap=0; next_counter=1.
REQ-034 counter=0xFFFFFFFF -> next_counter=0 and ctr_wrap=1; start pulses at busy cycles 5 and 40 -> ignored, exactly one done.
REQ-035 reset_n low at round cycle 30 -> all outputs 0 immediately; no done; a fresh start then yields the correct block.
REQ-036 start held high continuously -> back-to-back blocks, one done every 82 cycles, each block correct for the inputs sampled at its accept edge.
